// File: rtl/fifo_serial_drain.sv
// Drains a registered-read byte FIFO one word at a time onto an async serial line
// (start bit, data LSB-first, STOP_BITS stop bits).
module fifo_serial_drain #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_tx_en,
    input  logic              i_fifo_empty,
    output logic              o_fifo_rd_en,
    input  logic [DATA_W-1:0] i_fifo_rd_data,
    output logic              o_tx,
    output logic              o_busy,
    output logic              o_byte_done,
    output logic [15:0]       o_sent_count
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_W + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_POP, S_LOAD, S_START, S_DATA, S_STOP
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [BAUD_W-1:0]  r_baud;
    logic [BIT_W-1:0]   r_bit;
    logic [DATA_W-1:0]  r_shift;
    logic [15:0]        r_sent_count;
    logic               w_baud_tc;
    logic               w_frame_end;

    assign w_baud_tc   = (r_baud == BAUD_LAST);
    assign w_frame_end = (r_state == S_STOP) && w_baud_tc && (r_bit == STOP_LAST);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_tx_en && !i_fifo_empty) w_next = S_POP;
            S_POP:   w_next = S_LOAD;
            S_LOAD:  w_next = S_START;
            S_START: if (w_baud_tc) w_next = S_DATA;
            S_DATA:  if (w_baud_tc && (r_bit == DATA_LAST)) w_next = S_STOP;
            S_STOP:  if (w_frame_end) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // r_bit counts data bits in DATA and stop bits in STOP; both counters restart on any state change.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_baud       <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_sent_count <= '0;
        end else begin
            if (w_next != r_state) begin
                r_baud <= '0;
                r_bit  <= '0;
            end else if (r_state == S_START || r_state == S_DATA || r_state == S_STOP) begin
                if (w_baud_tc) begin
                    r_baud <= '0;
                    r_bit  <= r_bit + 1'b1;
                end else begin
                    r_baud <= r_baud + 1'b1;
                end
            end
            if (r_state == S_LOAD)
                r_shift <= i_fifo_rd_data;
            else if (r_state == S_DATA && w_baud_tc)
                r_shift <= r_shift >> 1;
            if (w_frame_end)
                r_sent_count <= r_sent_count + 16'd1;
        end
    end

    always_comb begin
        o_tx = 1'b1;
        case (r_state)
            S_START: o_tx = 1'b0;
            S_DATA:  o_tx = r_shift[0];
            default: o_tx = 1'b1;
        endcase
    end

    assign o_fifo_rd_en = (r_state == S_POP);
    assign o_busy       = (r_state != S_IDLE);
    assign o_byte_done  = w_frame_end;
    assign o_sent_count = r_sent_count;

endmodule

// File: tb/tb_fifo_serial_drain.sv
// Scoreboarded bench: stimulus pushes expected bytes, a line monitor checks every frame cycle.
module tb_fifo_serial_drain;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tx_en, fifo_empty, rd1, tx1, busy1, done1;
    logic [7:0]  rd_data;
    logic [15:0] sent1;
    logic        tx_en2, empty2, rd2, tx2, busy2, done2;
    logic [7:0]  rd_data2;
    logic [15:0] sent2;
    logic        sel;
    logic        m_tx, m_done;

    always #5 clk = ~clk;

    fifo_serial_drain #(.CLKS_PER_BIT(CPB), .DATA_W(8), .STOP_BITS(1)) dut1 (
        .i_clk(clk), .i_reset(rst_n), .i_tx_en(tx_en), .i_fifo_empty(fifo_empty),
        .o_fifo_rd_en(rd1), .i_fifo_rd_data(rd_data), .o_tx(tx1), .o_busy(busy1),
        .o_byte_done(done1), .o_sent_count(sent1));

    fifo_serial_drain #(.CLKS_PER_BIT(CPB), .DATA_W(8), .STOP_BITS(2)) dut2 (
        .i_clk(clk), .i_reset(rst_n), .i_tx_en(tx_en2), .i_fifo_empty(empty2),
        .o_fifo_rd_en(rd2), .i_fifo_rd_data(rd_data2), .o_tx(tx2), .o_busy(busy2),
        .o_byte_done(done2), .o_sent_count(sent2));

    assign m_tx   = sel ? tx2 : tx1;
    assign m_done = sel ? done2 : done1;

    int n_vec = 0, n_bad = 0;
    int cyc = 0, rd_cnt = 0, rd2_cnt = 0, rd_cyc = 0, start_cyc = 0;
    int gap = 1000, last_gap = -1;
    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] d, input int i);
        int k;
        k = i / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        return 1'b1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: registered read data presented from the pop cycle onward.
    always @(negedge clk) begin
        if (rd1 === 1'b1) begin
            rd_cnt++;
            rd_cyc = cyc;
            chk("pop_nonempty", 32'(fifo_q.size() != 0), 1);
            if (fifo_q.size() != 0) rd_data = fifo_q.pop_front();
        end
        fifo_empty = (fifo_q.size() == 0);
        if (rd2 === 1'b1) begin
            rd2_cnt++;
            rd_data2 = 8'h81;
            empty2   = 1'b1;
        end
    end

    // Line monitor / scoreboard.
    initial begin : monitor
        logic [7:0] d;
        int flen, bad;
        bit aborted;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                gap = 0;
                continue;
            end
            if (m_tx === 1'b0) begin
                last_gap  = gap;
                start_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("pending_frames", 32'(exp_q.size()), 1);
                end else begin
                    d       = exp_q.pop_front();
                    flen    = (9 + (sel ? 2 : 1)) * CPB;
                    bad     = 0;
                    aborted = 1'b0;
                    for (int i = 0; i < flen; i++) begin
                        if (i > 0) @(negedge clk);
                        if (rst_n !== 1'b1) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (m_tx !== exp_bit(d, i)) bad++;
                        if (m_done !== (i == flen - 1)) bad++;
                    end
                    if (!aborted) chk($sformatf("frame_%02h", d), 32'(bad), 0);
                end
                gap = 0;
            end else begin
                if (m_done === 1'b1) chk("stray_done", 32'(m_done), 0);
                gap++;
            end
        end
    end

    task automatic push(input logic [7:0] b);
        @(posedge clk);
        #1;
        fifo_q.push_back(b);
        exp_q.push_back(b);
    endtask

    task automatic wait_done1(input int lim);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (done1 !== 1'b1 && k < lim);
        chk("done1_seen", 32'(done1), 1);
    endtask

    task automatic wait_start1(input int lim);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (tx1 !== 1'b0 && k < lim);
        chk("start_seen", 32'(tx1), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        rst_n = 1'b0; tx_en = 1'b0; sel = 1'b0;
        tx_en2 = 1'b1; empty2 = 1'b1; rd_data = 8'h00; rd_data2 = 8'h00;
        fifo_empty = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx1), 1);
        chk("rst_busy", 32'(busy1), 0);
        chk("rst_rd_en", 32'(rd1), 0);
        chk("rst_sent", 32'(sent1), 0);
        rst_n = 1'b1;

        // single byte
        tx_en = 1'b1;
        push(8'hA5);
        wait_done1(200);
        @(negedge clk);
        chk("a5_sent", 32'(sent1), 1);
        chk("a5_pops", 32'(rd_cnt), 1);
        chk("a5_latency", 32'(start_cyc - rd_cyc), 2);

        // back-to-back
        push(8'h00);
        push(8'hFF);
        wait_done1(200);
        wait_done1(200);
        @(negedge clk);
        chk("b2b_pops", 32'(rd_cnt), 3);
        chk("b2b_gap", 32'(last_gap), 3);
        chk("b2b_sent", 32'(sent1), 3);
        repeat (20) @(negedge clk);
        chk("b2b_no_extra_pop", 32'(rd_cnt), 3);

        // empty FIFO with tx_en high
        hi = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx1 === 1'b1 && busy1 === 1'b0) hi++;
        end
        chk("empty_idle_high", 32'(hi), 20);
        chk("empty_no_pop", 32'(rd_cnt), 3);

        // tx_en dropped mid-frame
        push(8'h3C);
        push(8'h55);
        wait_start1(50);
        repeat (8) @(negedge clk);
        tx_en = 1'b0;
        wait_done1(200);
        repeat (30) @(negedge clk);
        chk("dis_pops", 32'(rd_cnt), 4);
        chk("dis_fifo_left", 32'(fifo_q.size()), 1);
        chk("dis_busy", 32'(busy1), 0);
        chk("dis_sent", 32'(sent1), 4);
        tx_en = 1'b1;
        wait_done1(200);
        @(negedge clk);
        chk("reen_sent", 32'(sent1), 5);

        // async reset mid-frame
        push(8'h5A);
        wait_start1(50);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_tx", 32'(tx1), 1);
        chk("arst_busy", 32'(busy1), 0);
        chk("arst_rd_en", 32'(rd1), 0);
        chk("arst_sent", 32'(sent1), 0);
        fifo_q.delete();
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // sent_count wrap
        @(negedge clk);
        force dut1.r_sent_count = 16'hFFFF;
        @(negedge clk);
        release dut1.r_sent_count;
        @(negedge clk);
        chk("wrap_preload", 32'(sent1), 32'h0000FFFF);
        push(8'hC3);
        wait_done1(200);
        @(negedge clk);
        chk("wrap_sent", 32'(sent1), 0);

        // two stop bits
        @(negedge clk);
        sel = 1'b1;
        exp_q.push_back(8'h81);
        empty2 = 1'b0;
        begin
            int k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (done2 !== 1'b1 && k < 200);
            chk("done2_seen", 32'(done2), 1);
        end
        @(negedge clk);
        chk("stop2_sent", 32'(sent2), 1);
        chk("stop2_pops", 32'(rd2_cnt), 1);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
